// File: rtl/design1_pkg.sv
// Shared widths, seven-segment glyph constants and the nibble-to-glyph lookup
// for the design1 display front-end.
package design1_pkg;

    localparam int unsigned SW_W       = 8;
    localparam int unsigned KEY_W      = 2;
    localparam int unsigned LED_W      = 10;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = BCD_DIGITS * NIBBLE_W;
    localparam int unsigned DP_BIT     = 7;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}, dp off
    localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
    localparam logic [SEG_W-1:0] SEG_A     = 8'h88;
    localparam logic [SEG_W-1:0] SEG_B     = 8'h83;
    localparam logic [SEG_W-1:0] SEG_C     = 8'hC6;
    localparam logic [SEG_W-1:0] SEG_D     = 8'hA1;
    localparam logic [SEG_W-1:0] SEG_E     = 8'h86;
    localparam logic [SEG_W-1:0] SEG_F     = 8'h8E;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
        logic [SEG_W-1:0] seg;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/design1_display_if.sv
// Board-facing pin bundle: switches and keys in, LED bar and six digits out.
interface design1_display_if;
    import design1_pkg::*;

    logic [SW_W-1:0]  switch;
    logic [KEY_W-1:0] key;
    logic [LED_W-1:0] leds;
    logic [SEG_W-1:0] hex0;
    logic [SEG_W-1:0] hex1;
    logic [SEG_W-1:0] hex2;
    logic [SEG_W-1:0] hex3;
    logic [SEG_W-1:0] hex4;
    logic [SEG_W-1:0] hex5;

    modport master (output switch, key, input leds, hex0, hex1, hex2, hex3, hex4, hex5);
    modport slave  (input switch, key, output leds, hex0, hex1, hex2, hex3, hex4, hex5);
endinterface

// File: rtl/design1_display_seg7_decoder.sv
// Combinational nibble-to-segment decoder; dp=1 lights the decimal point.
module seg7_decoder
    import design1_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    input  logic                dp,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c         = hex_to_seg(nibble);
        seg_c[DP_BIT] = ~dp;
    end

endmodule

// File: rtl/design1_display.sv
// Switch/LED mirror with hex, decimal and birthday seven-segment views.
// Optional build macro DESIGN1_DECIMAL_EN enables the hex4:hex2 decimal readout.
module design1_display
    import design1_pkg::*;
#(
    parameter logic [23:0] BDAY_BCD = 24'h061599
)
(
    input  logic              clk,
    input  logic              reset_n,
    design1_display_if.slave  bus
);

    logic [SW_W-1:0]   swMeta;
    logic [SW_W-1:0]   swSync;
    logic [KEY_W-1:0]  keyMeta;
    logic [KEY_W-1:0]  keySync;
    logic [KEY_W-1:0]  keyPrev;
    logic [KEY_W-1:0]  keyRise_c;
    logic              invert;
    logic              bday;
    logic [BCD_W-1:0]  bcd;
    logic              decBlank;

    logic [NUM_DIGITS*NIBBLE_W-1:0] digitNib;
    logic [NUM_DIGITS-1:0]          digitDp;
    logic [NUM_DIGITS-1:0]          digitBlank;
    logic [SEG_W-1:0]               segRaw [NUM_DIGITS];
    logic [SEG_W-1:0]               hexQ   [NUM_DIGITS];
    logic [LED_W-1:0]               ledsQ;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swMeta  <= '0;
            swSync  <= '0;
            keyMeta <= '0;
            keySync <= '0;
        end else begin
            swMeta  <= bus.switch;
            swSync  <= swMeta;
            keyMeta <= bus.key;
            keySync <= keyMeta;
        end
    end

    assign keyRise_c = keySync & ~keyPrev;

    // Mode flags toggle once per key press, regardless of hold time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keyPrev <= '0;
            invert  <= 1'b0;
            bday    <= 1'b0;
        end else begin
            keyPrev <= keySync;
            invert  <= invert ^ keyRise_c[0];
            bday    <= bday   ^ keyRise_c[1];
        end
    end

`ifdef DESIGN1_DECIMAL_EN
    logic [BCD_W+SW_W-1:0] dabble;

    // Double-dabble: add 3 to any BCD digit above 4, then shift in the next bit
    always_comb begin
        dabble = {BCD_W'(0), swSync};
        for (int i = 0; i < SW_W; i++) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                if (dabble[SW_W+NIBBLE_W*d +: NIBBLE_W] > 4'd4) begin
                    dabble[SW_W+NIBBLE_W*d +: NIBBLE_W] =
                        dabble[SW_W+NIBBLE_W*d +: NIBBLE_W] + 4'd3;
                end
            end
            dabble = dabble << 1;
        end
        bcd = dabble[SW_W +: BCD_W];
    end

    assign decBlank = 1'b0;
`else
    assign bcd      = '0;
    assign decBlank = 1'b1;
`endif

    // Per-digit source select: normal {blank, dec, hex} or birthday MM.DD.YY
    always_comb begin
        digitNib   = {NIBBLE_W'(0), bcd, swSync};
        digitDp    = '0;
        digitBlank = {1'b1, {BCD_DIGITS{decBlank}}, 2'b00};
        if (bday) begin
            digitNib   = BDAY_BCD;
            digitDp    = 6'b010100;
            digitBlank = '0;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
        seg7_decoder u_dec (
            .nibble (digitNib[gi*NIBBLE_W +: NIBBLE_W]),
            .dp     (digitDp[gi]),
            .seg_c  (segRaw[gi])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ledsQ <= '0;
            for (int g = 0; g < NUM_DIGITS; g++) hexQ[g] <= SEG_BLANK;
        end else begin
            ledsQ <= {bday, invert, swSync ^ {SW_W{invert}}};
            for (int g = 0; g < NUM_DIGITS; g++) hexQ[g] <= digitBlank[g] ? SEG_BLANK : segRaw[g];
        end
    end

    assign bus.leds = ledsQ;
    assign bus.hex0 = hexQ[0];
    assign bus.hex1 = hexQ[1];
    assign bus.hex2 = hexQ[2];
    assign bus.hex3 = hexQ[3];
    assign bus.hex4 = hexQ[4];
    assign bus.hex5 = hexQ[5];

endmodule

// File: tb/tb_design1_display.sv
// Directed self-checking bench for design1_display (both DESIGN1_DECIMAL_EN builds).
module tb_design1_display;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   nTests = 0;
    int   nFail  = 0;

    design1_display_if bus();

    design1_display #(.BDAY_BCD(24'h061599)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    wire [47:0] hexAll = {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    localparam logic [47:0] HEX_BLANK = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] HEX_BDAY  = 48'hC0_02_F9_12_90_90;
`ifdef DESIGN1_DECIMAL_EN
    localparam logic [47:0] HEX_00 = 48'hFF_C0_C0_C0_C0_C0;
    localparam logic [47:0] HEX_A5 = 48'hFF_F9_82_92_88_92;
    localparam logic [47:0] HEX_3C = 48'hFF_C0_82_C0_B0_C6;
    localparam logic [47:0] HEX_FF = 48'hFF_A4_92_92_8E_8E;
`else
    localparam logic [47:0] HEX_00 = 48'hFF_FF_FF_FF_C0_C0;
    localparam logic [47:0] HEX_A5 = 48'hFF_FF_FF_FF_88_92;
    localparam logic [47:0] HEX_3C = 48'hFF_FF_FF_FF_B0_C6;
    localparam logic [47:0] HEX_FF = 48'hFF_FF_FF_FF_8E_8E;
`endif

    function automatic logic [47:0] expNormal(input logic [7:0] v);
`ifdef DESIGN1_DECIMAL_EN
        return {8'hFF, glyph[4'(v / 100)], glyph[4'((v / 10) % 10)], glyph[4'(v % 10)],
                glyph[v[7:4]], glyph[v[3:0]]};
`else
        return {8'hFF, 24'hFF_FF_FF, glyph[v[7:4]], glyph[v[3:0]]};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseKey(input logic [1:0] k);
        bus.key = k;
        tick(1);
        bus.key = 2'b00;
    endtask

    initial begin
        bus.switch = 8'h00;
        bus.key    = 2'b00;
        reset_n    = 1'b0;
        tick(3);
        check("reset_leds", bus.leds, 10'h000);
        check("reset_hex", hexAll, HEX_BLANK);

        reset_n = 1'b1;
        tick(1);
        check("first_update_hex", hexAll, HEX_00);
        check("first_update_leds", bus.leds, 10'h000);

        // Switch latency: unchanged after 2 edges, visible after 3
        bus.switch = 8'hA5;
        tick(2);
        check("sw_latency_2", bus.leds, 10'h000);
        tick(1);
        check("sw_a5_leds", bus.leds, 10'b00_1010_0101);
        check("sw_a5_hex", hexAll, HEX_A5);

        // Invert key: flag after 3 edges, outputs on the 4th
        pulseKey(2'b01);
        tick(2);
        check("inv_latency_3", bus.leds, 10'b00_1010_0101);
        tick(1);
        check("inv_on_leds", bus.leds, 10'b01_0101_1010);
        check("inv_hex_unchanged", hexAll, HEX_A5);
        pulseKey(2'b01);
        tick(3);
        check("inv_off_leds", bus.leds, 10'b00_1010_0101);

        // Held key toggles only once, including on release
        bus.key = 2'b01;
        tick(20);
        check("inv_hold_leds", bus.leds, 10'b01_0101_1010);
        bus.key = 2'b00;
        tick(5);
        check("inv_release_leds", bus.leds, 10'b01_0101_1010);
        pulseKey(2'b01);
        tick(3);
        check("inv_restore_leds", bus.leds, 10'b00_1010_0101);

        // Birthday mode on and off
        pulseKey(2'b10);
        tick(3);
        check("bday_on_hex", hexAll, HEX_BDAY);
        check("bday_on_leds", bus.leds, 10'b10_1010_0101);
        pulseKey(2'b10);
        tick(3);
        check("bday_off_hex", hexAll, HEX_A5);
        check("bday_off_leds", bus.leds, 10'b00_1010_0101);

        // Both keys in the same cycle
        pulseKey(2'b11);
        tick(3);
        check("both_leds", bus.leds, 10'b11_0101_1010);
        check("both_hex", hexAll, HEX_BDAY);
        bus.switch = 8'h3C;
        tick(3);
        check("bday_sw_leds", bus.leds, 10'b11_1100_0011);
        check("bday_sw_hex", hexAll, HEX_BDAY);

        // Asynchronous reset mid-operation
        reset_n = 1'b0;
        #1;
        check("midreset_leds", bus.leds, 10'h000);
        check("midreset_hex", hexAll, HEX_BLANK);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("post_reset_leds", bus.leds, 10'h03C);
        check("post_reset_hex", hexAll, HEX_3C);

        // Full switch sweep in normal mode
        for (int v = 0; v < 256; v++) begin
            bus.switch = 8'(v);
            tick(3);
            check("sweep_leds", bus.leds, {2'b00, 8'(v)});
            check("sweep_hex", hexAll, expNormal(8'(v)));
        end
        check("sweep_ff_hex", hexAll, HEX_FF);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
